// File: rtl/note_pkg.sv
// Shared types and helpers for the falling-note lane engine.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package note_pkg;

    localparam int Y_W     = 10;
    localparam int SCORE_W = 16;
    localparam int COMBO_W = 8;

    typedef struct packed {
        logic           valid;
        logic [Y_W-1:0] y;
    } note_slot_t;

    // True when a note top edge lies inside the strike window around hit_y.
    function automatic logic in_window(input logic [Y_W-1:0] y,
                                       input int hit_y,
                                       input int hit_win);
        int yi;
        yi = int'(y);
        return (yi >= hit_y - hit_win) && (yi <= hit_y + hit_win);
    endfunction

endpackage

// File: rtl/note_lane.sv
// One falling-note lane: slot storage, per-frame scroll, key judgement, pixel hit test.
// Latency: hit/miss are combinational on the tick cycle; slot updates land on the tick edge.
// Backpressure: free=0 when every slot is live; spawn_we is ignored then.
// Ports: Clk/Reset, tick (one cycle per frame), press (new key press this frame),
//        spawn_we (write a new note at y=0), DrawX/DrawY (pixel), hit/miss/free/is_note.
module note_lane
    import note_pkg::*;
#(
    parameter int MAX_NOTES = 8,
    parameter int SPEED     = 4,
    parameter int HIT_Y     = 400,
    parameter int HIT_WIN   = 12,
    parameter int X_LO      = 160,
    parameter int NOTE_W    = 48,
    parameter int NOTE_H    = 16
)(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       tick,
    input  logic       press,
    input  logic       spawn_we,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       hit,
    output logic       miss,
    output logic       free,
    output logic       is_note
);
    localparam int          IDX_W   = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
    localparam logic [10:0] Y_LIMIT = 11'(HIT_Y + HIT_WIN);
    localparam logic [10:0] X_LO_C  = 11'(X_LO);
    localparam logic [10:0] X_HI_C  = 11'(X_LO + NOTE_W);

    note_slot_t       slots [MAX_NOTES];
    logic             found;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] free_idx;
    logic             pass_miss;

    always_comb begin
        found    = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        is_note  = 1'b0;
        // Scan downwards so the lowest qualifying index is the one left standing.
        for (int i = MAX_NOTES - 1; i >= 0; i--) begin
            if (slots[i].valid && in_window(slots[i].y, HIT_Y, HIT_WIN)) begin
                found   = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!slots[i].valid) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (slots[i].valid &&
                ({1'b0, DrawX} >= X_LO_C) && ({1'b0, DrawX} < X_HI_C) &&
                ({1'b0, DrawY} >= {1'b0, slots[i].y}) &&
                ({1'b0, DrawY} < {1'b0, slots[i].y} + 11'(NOTE_H)))
                is_note = 1'b1;
        end
    end

    assign hit = tick & press & found;

    // A note taken by this tick's hit must not also scroll past the window as a miss.
    always_comb begin
        pass_miss = 1'b0;
        for (int i = 0; i < MAX_NOTES; i++) begin
            if (slots[i].valid && !(hit && hit_idx == IDX_W'(i)) &&
                (11'(slots[i].y) + 11'(SPEED) > Y_LIMIT))
                pass_miss = 1'b1;
        end
    end

    assign miss = tick & ((press & ~found) | pass_miss);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < MAX_NOTES; i++)
                slots[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < MAX_NOTES; i++) begin
                if (hit && hit_idx == IDX_W'(i))
                    slots[i].valid <= 1'b0;
                else if (slots[i].valid) begin
                    if (11'(slots[i].y) + 11'(SPEED) > Y_LIMIT)
                        slots[i].valid <= 1'b0;
                    else
                        slots[i].y <= slots[i].y + Y_W'(SPEED);
                end
            end
        end else if (spawn_we && free) begin
            slots[free_idx] <= '{valid: 1'b1, y: '0};
        end
    end

endmodule

// File: rtl/note_lane_engine.sv
// Multi-lane falling-note engine: frame tick sync, spawn demux, lane array, score/combo.
// Latency: tick 3 Clk after frame_clk rises; score/combo/pulses update on the tick edge.
// Backpressure: spawn_ready=0 on tick cycles, for full lanes and for out-of-range lanes.
// Ports: Clk/Reset, frame_clk (async VGA_VS), spawn_valid/spawn_lane/spawn_ready,
//        lane_key, DrawX/DrawY, is_note, score, combo, hit_pulse, miss_pulse.
module note_lane_engine
    import note_pkg::*;
#(
    parameter int NUM_LANES  = 5,
    parameter int MAX_NOTES  = 8,
    parameter int SPEED      = 4,
    parameter int HIT_Y      = 400,
    parameter int HIT_WIN    = 12,
    parameter int LANE_X0    = 160,
    parameter int LANE_PITCH = 64,
    parameter int NOTE_W     = 48,
    parameter int NOTE_H     = 16,
    parameter int POINTS     = 10
)(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic                 spawn_valid,
    input  logic [2:0]           spawn_lane,
    output logic                 spawn_ready,
    input  logic [NUM_LANES-1:0] lane_key,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    output logic [NUM_LANES-1:0] is_note,
    output logic [SCORE_W-1:0]   score,
    output logic [COMBO_W-1:0]   combo,
    output logic                 hit_pulse,
    output logic                 miss_pulse
);
    logic                 fs1, fs2, fs3;
    logic                 tick;
    logic [NUM_LANES-1:0] key_prev, press;
    logic [NUM_LANES-1:0] lane_hit, lane_miss, lane_free, spawn_we;
    logic [7:0]           free_pad;
    logic                 lane_ok;
    logic [3:0]           hit_cnt;
    logic [SCORE_W:0]     score_sum;
    logic [COMBO_W:0]     combo_sum;

    // fs1/fs2 synchronise frame_clk; fs3 is the edge-detect history.
    assign tick  = fs2 & ~fs3;
    assign press = lane_key & ~key_prev;

    // Pad the free vector to the full 3-bit lane index range so spawn_lane can index it safely.
    always_comb begin
        free_pad                = '0;
        free_pad[NUM_LANES-1:0] = lane_free;
    end

    assign lane_ok     = int'(spawn_lane) < NUM_LANES;
    assign spawn_ready = ~tick & lane_ok & free_pad[spawn_lane];

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++)
            spawn_we[l] = spawn_valid & spawn_ready & (int'(spawn_lane) == l);
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        note_lane #(
            .MAX_NOTES (MAX_NOTES),
            .SPEED     (SPEED),
            .HIT_Y     (HIT_Y),
            .HIT_WIN   (HIT_WIN),
            .X_LO      (LANE_X0 + l * LANE_PITCH),
            .NOTE_W    (NOTE_W),
            .NOTE_H    (NOTE_H)
        ) u_lane (
            .Clk      (Clk),
            .Reset    (Reset),
            .tick     (tick),
            .press    (press[l]),
            .spawn_we (spawn_we[l]),
            .DrawX    (DrawX),
            .DrawY    (DrawY),
            .hit      (lane_hit[l]),
            .miss     (lane_miss[l]),
            .free     (lane_free[l]),
            .is_note  (is_note[l])
        );
    end

    always_comb begin
        hit_cnt = '0;
        for (int l = 0; l < NUM_LANES; l++)
            hit_cnt = hit_cnt + 4'(lane_hit[l]);
    end

    // One spare bit on each sum acts as the saturation flag.
    assign score_sum = {1'b0, score} + (SCORE_W + 1)'(POINTS * int'(hit_cnt));
    assign combo_sum = {1'b0, combo} + (COMBO_W + 1)'(hit_cnt);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fs1        <= 1'b0;
            fs2        <= 1'b0;
            fs3        <= 1'b0;
            key_prev   <= '0;
            score      <= '0;
            combo      <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            fs1        <= frame_clk;
            fs2        <= fs1;
            fs3        <= fs2;
            hit_pulse  <= tick & (|lane_hit);
            miss_pulse <= tick & (|lane_miss);
            if (tick) begin
                // Keys are sampled once per frame so a held key is one press.
                key_prev <= lane_key;
                score    <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                if (|lane_miss)
                    combo <= '0;
                else
                    combo <= combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_note_lane_engine.sv
module tb_note_lane_engine;
    localparam int NL = 5, MN = 8, SPD = 4, HY = 400, HW = 12;
    localparam int X0 = 160, PITCH = 64, NW = 48, NH = 16, PTS = 10;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          frame_clk;
    logic          spawn_valid;
    logic [2:0]    spawn_lane;
    logic          spawn_ready;
    logic [NL-1:0] lane_key;
    logic [9:0]    DrawX, DrawY;
    logic [NL-1:0] is_note;
    logic [15:0]   score;
    logic [7:0]    combo;
    logic          hit_pulse, miss_pulse;

    always #5 Clk = ~Clk;

    note_lane_engine dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_ready(spawn_ready),
        .lane_key(lane_key), .DrawX(DrawX), .DrawY(DrawY), .is_note(is_note),
        .score(score), .combo(combo), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    // Reference model state
    bit          mv [NL][MN];
    int          my [NL][MN];
    bit [NL-1:0] kprev;
    int          m_score, m_combo;

    typedef struct {
        int h;
        int m;
        int score;
        int combo;
    } exp_t;
    exp_t sb [$];

    int n_checks = 0, n_pass = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int l = 0; l < NL; l++)
            for (int i = 0; i < MN; i++) begin
                mv[l][i] = 0;
                my[l][i] = 0;
            end
        kprev = '0;
        m_score = 0;
        m_combo = 0;
    endtask

    task automatic model_tick(input logic [NL-1:0] keys, output int h, output int m);
        int hits, found;
        hits = 0;
        m = 0;
        for (int l = 0; l < NL; l++) begin
            if (keys[l] && !kprev[l]) begin
                found = -1;
                for (int i = 0; i < MN; i++)
                    if (found < 0 && mv[l][i] && my[l][i] >= HY - HW && my[l][i] <= HY + HW)
                        found = i;
                if (found >= 0) begin
                    mv[l][found] = 0;
                    hits++;
                end else m = 1;
            end
            for (int i = 0; i < MN; i++)
                if (mv[l][i]) begin
                    my[l][i] += SPD;
                    if (my[l][i] > HY + HW) begin
                        mv[l][i] = 0;
                        m = 1;
                    end
                end
        end
        kprev = keys;
        m_score = m_score + PTS * hits;
        if (m_score > 65535) m_score = 65535;
        if (m) m_combo = 0;
        else m_combo = (m_combo + hits > 255) ? 255 : m_combo + hits;
        h = (hits > 0) ? 1 : 0;
    endtask

    // One frame: raise frame_clk, push the model's expectation, watch the pulses, compare.
    task automatic frame(input logic [NL-1:0] keys);
        exp_t e;
        int hc, mc, hfirst;
        @(negedge Clk);
        lane_key  = keys;
        frame_clk = 1'b1;
        model_tick(keys, e.h, e.m);
        e.score = m_score;
        e.combo = m_combo;
        sb.push_back(e);
        hc = 0; mc = 0; hfirst = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            if (hit_pulse) begin
                hc++;
                if (hfirst == 0) hfirst = k;
            end
            if (miss_pulse) mc++;
            if (k == 4) frame_clk = 1'b0;
        end
        e = sb.pop_front();
        check_eq("hit_pulse", hc, e.h);
        check_eq("miss_pulse", mc, e.m);
        if (e.h != 0) check_eq("hit_latency", hfirst, 3);
        check_eq("score", int'(score), e.score);
        check_eq("combo", int'(combo), e.combo);
    endtask

    task automatic frames(input int n, input logic [NL-1:0] keys);
        repeat (n) frame(keys);
    endtask

    task automatic spawn(input int lane);
        int fidx;
        @(negedge Clk);
        spawn_valid = 1'b1;
        spawn_lane  = 3'(lane);
        #1;
        fidx = -1;
        if (lane < NL)
            for (int i = 0; i < MN; i++)
                if (fidx < 0 && !mv[lane][i]) fidx = i;
        check_eq("spawn_ready", int'(spawn_ready), (fidx >= 0) ? 1 : 0);
        @(posedge Clk);
        if (fidx >= 0) begin
            mv[lane][fidx] = 1;
            my[lane][fidx] = 0;
        end
        #1 spawn_valid = 1'b0;
    endtask

    task automatic probe(input int x, input int y);
        logic [NL-1:0] e;
        e = '0;
        for (int l = 0; l < NL; l++)
            for (int i = 0; i < MN; i++)
                if (mv[l][i] && x >= X0 + PITCH * l && x < X0 + PITCH * l + NW &&
                    y >= my[l][i] && y < my[l][i] + NH)
                    e[l] = 1'b1;
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1;
        check_eq("is_note", int'(is_note), int'(e));
    endtask

    task automatic check_idle();
        check_eq("rst_score", int'(score), 0);
        check_eq("rst_combo", int'(combo), 0);
        check_eq("rst_hit_pulse", int'(hit_pulse), 0);
        check_eq("rst_miss_pulse", int'(miss_pulse), 0);
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; spawn_valid = 1'b0; spawn_lane = '0;
        lane_key = '0; DrawX = '0; DrawY = '0;
        model_reset();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        #1;
        check_idle();
        probe(288, 205);

        // Single note scrolls 50 frames to y=200, then render edges.
        spawn(2);
        frames(50, '0);
        probe(288, 205); probe(288, 216); probe(287, 205);
        probe(335, 215); probe(336, 210);

        // Lane 0 hit at y=400; lane 2 note scrolls out as a miss meanwhile.
        spawn(0);
        frames(100, '0);
        probe(170, 405);
        frame(5'b00001);
        probe(170, 405);
        frame('0);

        // Two-lane simultaneous hit.
        spawn(0); spawn(3);
        frames(100, '0);
        frame(5'b01001);
        frame('0);

        // Press far from the window: miss, combo cleared, note kept.
        spawn(1);
        frames(25, '0);
        frame(5'b00010);
        probe(230, 106);
        frame('0);

        // Hit in lane 0 with a miss in lane 1 on the same frame.
        spawn(0);
        frames(100, '0);
        frame(5'b00011);
        frame('0);

        // Fill lane 4, lane 3 still accepts, lane 6 never does.
        for (int i = 0; i < MN + 1; i++) spawn(4);
        spawn(3);
        spawn(6);
        frames(10, '0);
        probe(420, 45); probe(360, 45);

        // Reset in the middle of play.
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        #1;
        check_idle();
        probe(420, 5); probe(420, 45);
        spawn(4);
        frames(3, '0);
        probe(420, 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/note_lane_engine.md
Name: note_lane_engine

Overview:
- Parametrised successor to the five fixed per-colour sprite blocks: one engine owns NUM_LANES falling-note lanes.
- Per lane it provides note storage, frame-rate scrolling, key-hit judgement, and per-lane pixel hit flags for the color mapper.
- Central score and combo counters are kept inside the block.
- Sits between the NIOS keycode decode (lane_key), the note spawner/music sequencer (spawn handshake), and color_mapper (is_note).

Parameters:
NUM_LANES, 5, number of lanes (1..8)
MAX_NOTES, 8, note slots per lane
SPEED, 4, pixels moved per frame tick
HIT_Y, 400, strike-line Y (note top edge)
HIT_WIN, 12, half-width of hit window in pixels
LANE_X0, 160, X of lane 0 left edge
LANE_PITCH, 64, X spacing between lanes
NOTE_W, 48, note width in pixels
NOTE_H, 16, note height in pixels
POINTS, 10, score added per hit

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  synchronous active-high reset
frame_clk  in  1  VGA_VS, asynchronous to the engine; rising edge = frame
spawn_valid  in  1  spawn request
spawn_lane  in  3  target lane index
spawn_ready  out  1  spawn accepted this cycle when valid&ready
lane_key  in  NUM_LANES  level, 1 = lane key held
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
is_note  out  NUM_LANES  pixel lies inside a live note of lane l
score  out  16  total score, saturating
combo  out  8  consecutive hits, saturating
hit_pulse  out  1  one-cycle strobe, at least one hit this tick
miss_pulse  out  1  one-cycle strobe, at least one miss this tick

Behaviour:
- Reset (synchronous, active-high, Clk): all slots invalid; score=0; combo=0; hit_pulse=0; miss_pulse=0; key history=0; synchroniser flops=0.
- is_note follows from state, so it is 0 after reset.
- Reset mid-operation discards all notes and counters on the next edge.
- frame_clk passes through a 2-flop synchroniser plus an edge detector. tick is high for exactly 1 Clk cycle, 3 cycles after frame_clk rises.
- Slot state: valid bit plus y[9:0]. Constraint: HIT_Y+HIT_WIN+SPEED < 1024, so y never wraps.
- Tick processing is one cycle. All judgements use pre-move positions, then survivors move.
- press[l] = lane_key[l] & ~key_prev[l]. key_prev is sampled on tick only, so presses are judged once per frame.
- In window means HIT_Y-HIT_WIN <= y <= HIT_Y+HIT_WIN.
- press with one or more in-window notes: clear the lowest-index such slot (one per lane per tick) and count a hit.
- press with no in-window note: count a miss. No slot is cleared.
- Each surviving valid slot gets y += SPEED. A slot whose new y exceeds HIT_Y+HIT_WIN is cleared and counts a miss.
- A note cleared by a hit is never also counted as a miss.
- Scoring, applied on the tick edge:
  - score += POINTS × total hits across lanes, saturating at 16'hFFFF.
  - If any miss occurred: combo=0, even when hits occurred the same tick.
  - Otherwise combo += hits, saturating at 255.
  - hit_pulse and miss_pulse are registered and valid the cycle after tick.
- Spawn:
  - spawn_ready = ~tick & (lane spawn_lane has a free slot) & (spawn_lane < NUM_LANES).
  - Accept: the lowest-index free slot gets valid=1, y=0.
  - Out-of-range lane: ready=0, request ignored.
  - Full lane: ready=0, requester holds.
  - Spawns are never accepted on a tick cycle.
- Render (combinational from registered slots): is_note[l]=1 iff some valid slot satisfies:
  - LANE_X0+l·LANE_PITCH <= DrawX < LANE_X0+l·LANE_PITCH+NOTE_W, and
  - y <= DrawY < y+NOTE_H.
  - Compare in 11 bits so there is no overflow.

Decomposition:
- Package note_pkg holds: note_slot_t struct {valid, y[9:0]}; constants Y_W=10, SCORE_W=16, COMBO_W=8; function in_window().
- Sub-module note_lane, instanced NUM_LANES times, contains:
  - the slot array, move/judge/clear logic, spawn write, render compare;
  - outputs hit, miss, free, is_note.
- The top contains the synchroniser, tick generation, spawn demux, and score/combo accumulation.

Test Plan:
- Reset, spawn lane 2, 50 ticks, no keys -> slot y=200; is_note[2]=1 at (DrawX=288, DrawY=205); 0 at DrawY=216; score=0.
- Spawn lane 0, 100 ticks (y=400), press lane_key[0] before tick 101 -> hit_pulse; score=10; combo=1; slot cleared.
- Press lane 1 with its only note at y=100 -> miss_pulse; combo reset 3→0; note retained; score unchanged.
- Ignore a note for 104 ticks (y 412→416) -> miss_pulse on that tick; slot freed; combo=0.
- Spawn 8 notes in lane 4 -> spawn_ready=0 for lane 4 while lane 3 still accepts; spawn_lane=6 is never accepted.
- Lanes 0 and 3 hit on the same tick -> score +20, combo +2. Next, a hit in lane 0 plus a miss in lane 1 -> score +10, combo=0, both pulses high. Reset asserted mid-sequence -> everything returns to 0.
